dram_aes_round_seq: RTL and testbench
=====================================

DRAM_AES_ROUND_SEQ -- requirements
Module: dram_aes_round_seq

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum cycles spent in WAIT for one result before abort.
REQ-002 Parameter NR, default 10: number of AES rounds (AES-128).
REQ-003 CLK  in  1  single clock; all state changes on rising edge.
REQ-004 RSTn  in  1  reset, asynchronous, active-low.
REQ-005 EN  in  1  enable; low forces abort to IDLE.
REQ-006 Drdy  in  1  plaintext strobe; sampled only in IDLE.
REQ-007 Din  in  128  plaintext, byte 0 in [127:120].
REQ-008 Dout  out  128  ciphertext register.
REQ-009 Dvld  out  1  one-cycle pulse, Dout valid.
REQ-010 BSY  out  1  high in any state except IDLE.
REQ-011 ERR  out  1  one-cycle pulse on timeout.
REQ-012 Trigger  out  1  high while op round 0 is issued or outstanding (scope trigger).
REQ-013 op_valid  out  1  DRAM operation request.
REQ-014 op_ready  in  1  DRAM engine accepts request.
REQ-015 op_round  out  4  round-key index 0..NR held in DRAM.
REQ-016 op_mode  out  1  0 = SubBytes(data ^ key), 1 = data ^ key only.
REQ-017 op_data  out  128  state sent to DRAM array.
REQ-018 res_valid  in  1  DRAM result strobe.
REQ-019 res_data  in  128  DRAM result.

Function
REQ-020 FSM states IDLE, ISSUE, WAIT, DONE; no other states.
REQ-021 IDLE: Drdy=1 and EN=1 -> load state <= Din, round <= 0, go ISSUE.
REQ-022 ISSUE: op_valid=1; op_round/op_mode/op_data stable until handshake (op_valid & op_ready at edge) -> WAIT.
REQ-023 op_mode = 0 for rounds 0..NR-1, 1 for round NR.
REQ-024 WAIT: res_valid=1, round<NR-1 -> state <= MixColumns(ShiftRows(res_data)), round+1, go ISSUE.
REQ-025 WAIT: res_valid=1, round=NR-1 -> state <= ShiftRows(res_data), round <= NR, go ISSUE.
REQ-026 WAIT: res_valid=1, round=NR -> Dout <= res_data, go DONE.
REQ-027 DONE: Dvld=1 for exactly one cycle, then IDLE.
REQ-028 res_valid outside WAIT is ignored; a handshake and res_valid in the same cycle cannot occur (res counted only in WAIT).
REQ-029 Drdy while BSY=1 is ignored, not queued.
REQ-030 WAIT cycle counter resets on entry; reaching TIMEOUT without res_valid -> ERR pulse, Dvld not asserted, Dout unchanged, go IDLE.
REQ-031 EN=0 in any state -> next state IDLE, op_valid deasserts next cycle, partial state discarded, no Dvld/ERR.
REQ-032 Latency with op_ready=1 and res_valid one cycle after handshake: Dvld high in cycle 22 after the Drdy sampling edge (11 ops x 2 cycles).
REQ-033 op_ready held low stalls ISSUE indefinitely; timeout applies only to WAIT.

Reset
REQ-034 RSTn low: FSM IDLE, round 0, state 0, Dout 0, Dvld/ERR/BSY/Trigger/op_valid 0, counter 0, immediately and independent of CLK.
REQ-035 Reset assertion mid-operation discards it; no outputs pulse on release.

Structure
REQ-036 Shared package holds FSM state encoding, OP_MODE_SBOX/OP_MODE_XOR constants, and AES block width (128).
REQ-037 One combinational sub-module aes_sr_mc (ShiftRows, optional MixColumns by select input); no S-box in this block.

Verification
REQ-038 Bench DRAM model returns SubBytes/XOR with FIPS-197 round keys for key 000102030405060708090a0b0c0d0e0f; Din=00112233445566778899aabbccddeeff -> Dout=69c4e0d86a7b0430d8cdb78070b4c55a, Dvld 22 cycles after Drdy.
REQ-039 Same vector, op_ready low 3 cycles per request, result delay 4 cycles -> identical Dout, op_* stable while stalled, Trigger high only for round 0.
REQ-040 Model withholds res_valid for round 5 -> ERR pulse after TIMEOUT cycles in WAIT, no Dvld, BSY low next cycle.
REQ-041 EN dropped during round 3 WAIT -> IDLE next cycle, no Dvld; later Drdy with EN=1 encrypts correctly.
REQ-042 RSTn asserted mid-round 7 -> all outputs zero asynchronously; Drdy during BSY and spurious res_valid in IDLE -> ignored.

Source files
------------

// File: rtl/dram_aes_round_seq_pkg.sv
// dram_aes_round_seq_pkg: shared FSM encoding, op-mode constants and GF(2^8) helper
// for the DRAM-offloaded AES round sequencer.
package dram_aes_round_seq_pkg;
    localparam int BLK_W = 128;
    localparam logic OP_MODE_SBOX = 1'b0;
    localparam logic OP_MODE_XOR = 1'b1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction
endpackage

// File: rtl/dram_aes_round_seq_sr_mc.sv
// aes_sr_mc: combinational ShiftRows with optional MixColumns; byte 0 sits in [127:120],
// state bytes are column-major (byte r+4c is row r, column c).
module aes_sr_mc
    import dram_aes_round_seq_pkg::*;
(
    input logic [BLK_W-1:0] data,
    input logic mix,
    output logic [BLK_W-1:0] result
);
    logic [7:0] s [16];
    logic [7:0] m [16];

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign s[4*c+r] = data[BLK_W-1-8*(4*((c+r)%4)+r) -: 8];
            // 2*a[r] ^ 3*a[r+1] ^ a[r+2] ^ a[r+3] within the column
            assign m[4*c+r] = xtime(s[4*c+r]) ^ xtime(s[4*c+(r+1)%4]) ^ s[4*c+(r+1)%4]
                            ^ s[4*c+(r+2)%4] ^ s[4*c+(r+3)%4];
            assign result[BLK_W-1-8*(4*c+r) -: 8] = mix ? m[4*c+r] : s[4*c+r];
        end
    end
endmodule

// File: rtl/dram_aes_round_seq.sv
// dram_aes_round_seq: AES-128 round sequencer; AddRoundKey/SubBytes run in the DRAM engine,
// ShiftRows/MixColumns are applied locally between operations.
module dram_aes_round_seq
    import dram_aes_round_seq_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int NR = 10
) (
    input logic CLK,
    input logic RSTn,
    input logic EN,
    input logic Drdy,
    input logic [BLK_W-1:0] Din,
    output logic [BLK_W-1:0] Dout,
    output logic Dvld,
    output logic BSY,
    output logic ERR,
    output logic Trigger,
    output logic op_valid,
    input logic op_ready,
    output logic [3:0] op_round,
    output logic op_mode,
    output logic [BLK_W-1:0] op_data,
    input logic res_valid,
    input logic [BLK_W-1:0] res_data
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [3:0] LAST = 4'(NR);
    localparam logic [CW-1:0] CNT_END = CW'(TIMEOUT - 1);

    state_t fsm;
    logic [3:0] round;
    logic [BLK_W-1:0] blk, sr_out;
    logic [CW-1:0] cnt;

    aes_sr_mc u_sr_mc (
        .data(res_data),
        .mix(round != LAST - 4'd1),
        .result(sr_out)
    );

    assign op_round = round;
    assign op_mode = (round == LAST) ? OP_MODE_XOR : OP_MODE_SBOX;
    assign op_data = blk;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            fsm <= IDLE;
            round <= '0;
            blk <= '0;
            Dout <= '0;
            cnt <= '0;
            Dvld <= 1'b0;
            ERR <= 1'b0;
            BSY <= 1'b0;
            Trigger <= 1'b0;
            op_valid <= 1'b0;
        end else begin
            Dvld <= 1'b0;
            ERR <= 1'b0;
            if (!EN) begin
                fsm <= IDLE;
                round <= '0;
                BSY <= 1'b0;
                Trigger <= 1'b0;
                op_valid <= 1'b0;
            end else begin
                case (fsm)
                    IDLE: if (Drdy) begin
                        blk <= Din;
                        round <= '0;
                        fsm <= ISSUE;
                        BSY <= 1'b1;
                        Trigger <= 1'b1;
                        op_valid <= 1'b1;
                    end
                    ISSUE: if (op_ready) begin
                        fsm <= WAIT;
                        op_valid <= 1'b0;
                        cnt <= '0;
                    end
                    WAIT: if (res_valid) begin
                        Trigger <= 1'b0;
                        if (round == LAST) begin
                            Dout <= res_data;
                            Dvld <= 1'b1;
                            fsm <= DONE;
                        end else begin
                            blk <= sr_out;
                            round <= round + 4'd1;
                            fsm <= ISSUE;
                            op_valid <= 1'b1;
                        end
                    end else if (cnt == CNT_END) begin
                        ERR <= 1'b1;
                        fsm <= IDLE;
                        round <= '0;
                        BSY <= 1'b0;
                        Trigger <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                    DONE: begin
                        fsm <= IDLE;
                        round <= '0;
                        BSY <= 1'b0;
                    end
                    default: fsm <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_dram_aes_round_seq.sv
// tb_dram_aes_round_seq: directed vectors against a DRAM engine model that performs
// SubBytes(data ^ round_key) / data ^ round_key with FIPS-197 key expansion.
module tb_dram_aes_round_seq;
    logic CLK = 1'b0;
    logic RSTn, EN, Drdy;
    logic [127:0] Din, Dout, op_data, res_data;
    logic Dvld, BSY, ERR, Trigger, op_valid, op_ready, op_mode, res_valid;
    logic [3:0] op_round;

    dram_aes_round_seq dut (
        .CLK(CLK), .RSTn(RSTn), .EN(EN), .Drdy(Drdy), .Din(Din), .Dout(Dout),
        .Dvld(Dvld), .BSY(BSY), .ERR(ERR), .Trigger(Trigger),
        .op_valid(op_valid), .op_ready(op_ready), .op_round(op_round),
        .op_mode(op_mode), .op_data(op_data), .res_valid(res_valid), .res_data(res_data)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [127:0] key, pt, ct;
        int stall, dly, lat;
    } vec_t;

    vec_t vecs [4];
    logic [7:0] sbox [256];
    logic [127:0] rk [11];
    logic [7:0] inv;
    int errors = 0, checks = 0;
    int m_stall = 0, m_dly = 1, m_skip = -1;
    logic spur_en = 1'b0;
    int dvld_seen = 0, err_seen = 0, trig_bad = 0, ord_bad = 0, stall_bad = 0;
    int rdy_wait, res_wait, m_round, lat, d0;
    logic [127:0] pend, h_data;
    logic [3:0] h_round;
    logic h_mode;

    localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_A = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_A = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B = 128'h3925841d02dc09fbdc118597196a0b32;

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] x);
        logic [127:0] y;
        for (int i = 0; i < 16; i++) y[8*i +: 8] = sbox[x[8*i +: 8]];
        return y;
    endfunction

    task automatic expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0] rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int k = 0; k < 11; k++) rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start(input logic [127:0] d);
        @(negedge CLK);
        Din = d;
        Drdy = 1'b1;
        @(negedge CLK);
        Drdy = 1'b0;
    endtask

    task automatic wait_end(output int n);
        n = 0;
        while (!Dvld && !ERR && n < 2000) begin
            @(negedge CLK);
            n++;
        end
    endtask

    // DRAM engine model: acts at falling edges, tracks its own round count
    initial begin
        op_ready = 1'b0;
        res_valid = 1'b0;
        res_data = '0;
        rdy_wait = 0;
        res_wait = 0;
        m_round = 0;
        forever begin
            @(negedge CLK);
            if (Dvld) dvld_seen++;
            if (ERR) err_seen++;
            if (Trigger !== (BSY && m_round == 0)) trig_bad++;
            res_valid = 1'b0;
            if (!BSY) begin
                op_ready = 1'b0;
                rdy_wait = 0;
                res_wait = 0;
                m_round = 0;
                res_valid = spur_en;
            end else begin
                if (op_ready) begin
                    op_ready = 1'b0;
                    res_wait = m_dly;
                end
                if (res_wait > 0) begin
                    res_wait--;
                    if (res_wait == 0) begin
                        res_valid = (m_round != m_skip);
                        res_data = pend;
                        if (res_valid) m_round++;
                    end
                end else if (op_valid) begin
                    if (op_round !== 4'(m_round) || op_mode !== (m_round == 10)) ord_bad++;
                    if (rdy_wait == 0) begin
                        h_data = op_data;
                        h_round = op_round;
                        h_mode = op_mode;
                    end else if ({op_data, op_round, op_mode} !== {h_data, h_round, h_mode}) begin
                        stall_bad++;
                    end
                    if (rdy_wait == m_stall) begin
                        op_ready = 1'b1;
                        rdy_wait = 0;
                        pend = (m_round == 10) ? (op_data ^ rk[10]) : sub_bytes(op_data ^ rk[m_round]);
                    end else begin
                        rdy_wait++;
                    end
                end
            end
        end
    end

    initial begin
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                    ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
        vecs[0] = '{KEY_A, PT_A, CT_A, 0, 1, 22};
        vecs[1] = '{KEY_A, PT_A, CT_A, 3, 4, 88};
        vecs[2] = '{KEY_B, PT_B, CT_B, 0, 1, 22};
        vecs[3] = '{KEY_B, PT_B, CT_B, 1, 2, 44};

        RSTn = 1'b0;
        EN = 1'b1;
        Drdy = 1'b0;
        Din = '0;
        repeat (2) @(negedge CLK);
        chk("rst_dout", Dout, 0);
        chk("rst_flags", {Dvld, ERR, BSY, Trigger, op_valid}, 0);
        chk("rst_op", {op_round, op_data}, 0);
        RSTn = 1'b1;
        @(negedge CLK);

        foreach (vecs[i]) begin
            expand(vecs[i].key);
            m_stall = vecs[i].stall;
            m_dly = vecs[i].dly;
            d0 = dvld_seen;
            start(vecs[i].pt);
            wait_end(lat);
            chk($sformatf("v%0d_latency", i), 128'(lat), 128'(vecs[i].lat));
            chk($sformatf("v%0d_dvld", i), 128'(Dvld), 1);
            chk($sformatf("v%0d_dout", i), Dout, vecs[i].ct);
            @(negedge CLK);
            chk($sformatf("v%0d_after", i), {Dvld, BSY}, 0);
            @(negedge CLK);
            chk($sformatf("v%0d_one_pulse", i), 128'(dvld_seen - d0), 1);
        end

        d0 = dvld_seen;
        spur_en = 1'b1;
        repeat (3) @(negedge CLK);
        spur_en = 1'b0;
        repeat (2) @(negedge CLK);
        chk("spur_idle", {BSY, Dvld, ERR}, 0);
        chk("spur_dout", Dout, CT_B);
        chk("spur_no_dvld", 128'(dvld_seen - d0), 0);

        expand(KEY_A);
        m_stall = 0;
        m_dly = 1;
        m_skip = 5;
        start(PT_A);
        wait_end(lat);
        chk("to_latency", 128'(lat), 266);
        chk("to_err_flags", {ERR, Dvld, BSY}, 3'b100);
        chk("to_dout_kept", Dout, CT_B);
        @(negedge CLK);
        chk("to_err_pulse", {ERR, BSY}, 0);
        m_skip = -1;

        d0 = dvld_seen;
        start(PT_A);
        repeat (7) @(negedge CLK);
        chk("en_round3_wait", {op_round, op_valid, BSY}, {4'd3, 1'b0, 1'b1});
        EN = 1'b0;
        @(negedge CLK);
        chk("en_abort", {BSY, op_valid, Trigger, Dvld, ERR}, 0);
        repeat (2) @(negedge CLK);
        EN = 1'b1;
        chk("en_no_dvld", 128'(dvld_seen - d0), 0);

        start(PT_A);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            Drdy = (i == 2);
            Din = PT_B;
        end
        wait_end(lat);
        chk("busy_latency", 128'(lat), 17);
        chk("busy_dout", Dout, CT_A);
        repeat (2) @(negedge CLK);
        chk("busy_one_dvld", 128'(dvld_seen - d0), 1);
        chk("busy_idle", 128'(BSY), 0);

        d0 = dvld_seen;
        start(PT_A);
        repeat (15) @(negedge CLK);
        chk("rst_round7", {op_round, op_valid}, {4'd7, 1'b0});
        #2 RSTn = 1'b0;
        #1;
        chk("arst_dout", Dout, 0);
        chk("arst_flags", {Dvld, ERR, BSY, Trigger, op_valid}, 0);
        chk("arst_op", {op_round, op_data}, 0);
        @(negedge CLK);
        RSTn = 1'b1;
        repeat (4) @(negedge CLK);
        chk("arst_release", {BSY, Dvld, ERR}, 0);
        chk("arst_no_dvld", 128'(dvld_seen - d0), 0);
        chk("err_pulses", 128'(err_seen), 1);

        chk("trigger_round0", 128'(trig_bad), 0);
        chk("op_round_mode", 128'(ord_bad), 0);
        chk("op_stable_stall", 128'(stall_bad), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
